// File: rtl/str_sdiv_post.sv
// str_sdiv_post: pairs unsigned divider results with queued sign/exception tags and restores signs.
// Define STR_SDIV_POST_SAT_EN to saturate divide-by-zero and overflow results.
module str_sdiv_post #(
   parameter int DW        = 8,
   parameter int TAG_DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tag_qneg,
   input  logic          tag_rneg,
   input  logic          tag_dz,
   input  logic          tag_valid,
   output logic          tag_ready,
   input  logic [DW-1:0] div_quotient,
   input  logic [DW-1:0] div_remainder,
   input  logic          div_last,
   input  logic          div_valid,
   output logic          div_ready,
   output logic [DW-1:0] out_quotient,
   output logic [DW-1:0] out_remainder,
   output logic          out_dz,
   output logic          out_ovf,
   output logic          out_last,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(TAG_DEPTH);

   typedef struct packed {
      logic qneg;
      logic rneg;
      logic dz;
   } tag_t;

   function automatic logic signed [DW-1:0] sign_restore(input logic [DW-1:0] mag, input logic neg);
      logic signed [DW-1:0] s;
      s = $signed(mag);
      return neg ? -s : s;
   endfunction

`ifdef STR_SDIV_POST_SAT_EN
   function automatic logic signed [DW-1:0] sat_quotient(input logic neg);
      return neg ? $signed({1'b1, {(DW-1){1'b0}}}) : $signed({1'b0, {(DW-1){1'b1}}});
   endfunction
`endif

   tag_t          tag_mem_q [TAG_DEPTH];
   tag_t          tag_in;
   tag_t          tag_head;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push;
   logic          pop;
   logic          out_free;

   logic signed [DW-1:0] q_res;
   logic signed [DW-1:0] r_res;
   logic                 ovf_res;

   logic [DW-1:0] out_quotient_q, out_quotient_d;
   logic [DW-1:0] out_remainder_q, out_remainder_d;
   logic          out_dz_q, out_dz_d;
   logic          out_ovf_q, out_ovf_d;
   logic          out_last_q, out_last_d;
   logic          out_valid_q, out_valid_d;

   // Handshakes: a result is only consumed when a tag is queued and the output slot can take it.
   assign tag_in    = '{qneg: tag_qneg, rneg: tag_rneg, dz: tag_dz};
   assign tag_head  = tag_mem_q[rd_ptr_q];
   assign tag_ready = (count_q != DEPTH_C);
   assign out_free  = out_ready | ~out_valid_q;
   assign div_ready = (count_q != '0) & out_free;
   assign push      = tag_valid & tag_ready;
   assign pop       = div_valid & div_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem_q[wr_ptr_q] <= tag_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Sign restore of the head result; overflow means a non-negative quotient whose magnitude hit the sign bit.
   always_comb begin
      q_res   = sign_restore(div_quotient, tag_head.qneg);
      r_res   = sign_restore(div_remainder, tag_head.rneg);
      ovf_res = ~tag_head.qneg & div_quotient[DW-1];
`ifdef STR_SDIV_POST_SAT_EN
      if (tag_head.dz) begin
         q_res = sat_quotient(tag_head.qneg);
         r_res = '0;
      end else if (ovf_res) begin
         q_res = sat_quotient(1'b0);
      end
`endif
   end

   always_comb begin
      out_quotient_d  = out_quotient_q;
      out_remainder_d = out_remainder_q;
      out_dz_d        = out_dz_q;
      out_ovf_d       = out_ovf_q;
      out_last_d      = out_last_q;
      out_valid_d     = out_valid_q;
      if (pop) begin
         out_quotient_d  = $unsigned(q_res);
         out_remainder_d = $unsigned(r_res);
         out_dz_d        = tag_head.dz;
         out_ovf_d       = ovf_res;
         out_last_d      = div_last;
         out_valid_d     = 1'b1;
      end else if (out_ready) begin
         out_valid_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_quotient_q  <= '0;
         out_remainder_q <= '0;
         out_dz_q        <= 1'b0;
         out_ovf_q       <= 1'b0;
         out_last_q      <= 1'b0;
         out_valid_q     <= 1'b0;
      end else begin
         out_quotient_q  <= out_quotient_d;
         out_remainder_q <= out_remainder_d;
         out_dz_q        <= out_dz_d;
         out_ovf_q       <= out_ovf_d;
         out_last_q      <= out_last_d;
         out_valid_q     <= out_valid_d;
      end
   end

   assign out_quotient  = out_quotient_q;
   assign out_remainder = out_remainder_q;
   assign out_dz        = out_dz_q;
   assign out_ovf       = out_ovf_q;
   assign out_last      = out_last_q;
   assign out_valid     = out_valid_q;

endmodule

// File: tb/tb_str_sdiv_post.sv
// Scoreboard bench for str_sdiv_post: random signed operand pairs feed a front-end/divider model,
// expected results come from plain signed integer division.
module tb_str_sdiv_post;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tag_qneg = 1'b0, tag_rneg = 1'b0, tag_dz = 1'b0, tag_valid = 1'b0;
   logic       tag_ready;
   logic [7:0] div_quotient = '0, div_remainder = '0;
   logic       div_last = 1'b0, div_valid = 1'b0;
   logic       div_ready;
   logic [7:0] out_quotient, out_remainder;
   logic       out_dz, out_ovf, out_last, out_valid;
   logic       out_ready = 1'b0;

   str_sdiv_post #(.DW(8), .TAG_DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .tag_qneg(tag_qneg), .tag_rneg(tag_rneg), .tag_dz(tag_dz),
      .tag_valid(tag_valid), .tag_ready(tag_ready),
      .div_quotient(div_quotient), .div_remainder(div_remainder), .div_last(div_last),
      .div_valid(div_valid), .div_ready(div_ready),
      .out_quotient(out_quotient), .out_remainder(out_remainder),
      .out_dz(out_dz), .out_ovf(out_ovf), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct { int a; int b; bit last; } op_t;

   op_t         ops[$];
   logic [18:0] sb[$];
   int          tag_idx = 0, div_idx = 0;
   int          tag_prob = 100, div_prob = 100, out_prob = 100;
   int          n_vec = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: truncating signed division on integers; divider returns all-ones quotient on /0.
   function automatic logic [18:0] model(input op_t o);
      int qt, rt;
      bit dz, ovf;
      dz = (o.b == 0);
      if (dz) begin
         qt  = (o.a < 0) ? -255 : 255;
         rt  = o.a;
         ovf = (o.a >= 0);
      end else begin
         qt  = o.a / o.b;
         rt  = o.a % o.b;
         ovf = (qt > 127);
      end
`ifdef STR_SDIV_POST_SAT_EN
      if (dz) begin
         qt = (o.a < 0) ? -128 : 127;
         rt = 0;
      end else if (ovf) begin
         qt = 127;
      end
`endif
      return {qt[7:0], rt[7:0], dz, ovf, o.last};
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic cycle();
      bit tf, df;
      int m;
      @(negedge clk);
      tf = tag_valid && tag_ready;
      df = div_valid && div_ready;
      @(posedge clk);
      #1;
      if (tf) begin
         sb.push_back(model(ops[tag_idx]));
         tag_idx++;
      end
      if (df) div_idx++;
      if (!(tag_valid && !tf)) begin
         if (tag_idx < ops.size() && $urandom_range(99) < tag_prob) begin
            tag_qneg  = (ops[tag_idx].a < 0) != (ops[tag_idx].b < 0);
            tag_rneg  = (ops[tag_idx].a < 0);
            tag_dz    = (ops[tag_idx].b == 0);
            tag_valid = 1'b1;
         end else tag_valid = 1'b0;
      end
      if (!(div_valid && !df)) begin
         if (div_idx < ops.size() && $urandom_range(99) < div_prob) begin
            if (ops[div_idx].b == 0) begin
               div_quotient = 8'hFF;
               m = iabs(ops[div_idx].a);
            end else begin
               m = iabs(ops[div_idx].a) / iabs(ops[div_idx].b);
               div_quotient = m[7:0];
               m = iabs(ops[div_idx].a) % iabs(ops[div_idx].b);
            end
            div_remainder = m[7:0];
            div_last  = ops[div_idx].last;
            div_valid = 1'b1;
         end else div_valid = 1'b0;
      end
      out_ready = ($urandom_range(99) < out_prob);
   endtask

   task automatic clear_stream();
      ops.delete();
      sb.delete();
      tag_idx = 0;
      div_idx = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      tag_valid = 1'b0;
      div_valid = 1'b0;
      clear_stream();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic add_op(input int a, input int b);
      op_t o;
      o.a = a;
      o.b = b;
      o.last = $urandom_range(3) == 0;
      ops.push_back(o);
   endtask

   task automatic gen_batch(input int n);
      int a, b;
      for (int i = 0; i < n; i++) begin
         a = int'($urandom_range(255)) - 128;
         case ($urandom_range(9))
            0:       b = 0;
            1:       b = -1;
            default: b = int'($urandom_range(255)) - 128;
         endcase
         add_op(a, b);
      end
   endtask

   task automatic run_until_done(input int budget);
      int n = 0;
      while ((div_idx < ops.size() || sb.size() != 0) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_in_budget", (n < budget), 1);
   endtask

   // Monitor: pops the scoreboard on every output beat and checks stability, latency and reset state.
   logic [18:0] held_val;
   bit          held = 0, lat_pend = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs", {out_quotient, out_remainder, out_dz, out_ovf, out_last, out_valid}, 0);
         chk("reset_ready", {tag_ready, div_ready}, 2'b10);
         held = 0;
         lat_pend = 0;
      end else begin
         if (lat_pend) chk("latency_valid", out_valid, 1);
         if (held) chk("bp_stable", {out_quotient, out_remainder, out_dz, out_ovf, out_last, out_valid},
                       {held_val, 1'b1});
         if (out_valid && !out_ready) chk("bp_div_ready", div_ready, 0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_output: got %h with empty scoreboard",
                        {out_quotient, out_remainder, out_dz, out_ovf, out_last});
            end else begin
               chk("result", {out_quotient, out_remainder, out_dz, out_ovf, out_last}, sb.pop_front());
            end
         end
         held = out_valid && !out_ready;
         held_val = {out_quotient, out_remainder, out_dz, out_ovf, out_last};
         lat_pend = div_valid && div_ready;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed cases, first with an empty tag FIFO so results must wait.
      add_op(-7, 2);   add_op(7, -2);   add_op(-128, -1); add_op(-5, 0);
      add_op(5, 0);    add_op(0, -3);   add_op(127, 1);   add_op(-128, 1);
      add_op(-1, 127); add_op(100, -7);
      tag_prob = 0; div_prob = 100; out_prob = 100;
      repeat (4) begin
         cycle();
         chk("empty_div_ready", div_ready, 0);
         chk("empty_tag_ready", tag_ready, 1);
      end
      tag_prob = 100;
      run_until_done(200);

      // Fill the FIFO with no results offered.
      clear_stream();
      gen_batch(20);
      tag_prob = 100; div_prob = 0; out_prob = 100;
      repeat (24) cycle();
      chk("full_push_count", tag_idx, 16);
      chk("full_tag_ready", tag_ready, 0);
      div_prob = 100;
      run_until_done(400);
      repeat (2) cycle();
      chk("drained_tag_ready", tag_ready, 1);
      chk("drained_div_ready", div_ready, 0);

      // Random stress with a reset pulse mid-stream.
      clear_stream();
      gen_batch(300);
      tag_prob = 70; div_prob = 70; out_prob = 60;
      repeat (150) cycle();
      do_reset();
      chk("post_reset_tag_ready", tag_ready, 1);
      chk("post_reset_out_valid", out_valid, 0);
      gen_batch(300);
      run_until_done(20000);

      clear_stream();
      gen_batch(300);
      tag_prob = 50; div_prob = 80; out_prob = 40;
      run_until_done(20000);
      chk("scoreboard_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
